vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen_if.sv | 31 +++
 rtl/vga_timing_gen.sv | 156 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between vga_timing_gen (master) and its consumers (slave).
interface vga_timing_gen_if #(
  parameter int COORD_W = 10
);
  logic               Enable;
  logic               Running;
  logic               pixel_ce;
  logic               pixel_clk;
  logic               hs;
  logic               vs;
  logic               blank;
  logic               sync;
  logic [COORD_W-1:0] DrawX;
  logic [COORD_W-1:0] DrawY;
  logic               frame_start;
  logic               line_start;
  logic               vblank_start;
  logic [15:0]        FrameCount;

  modport master (
    input  Enable,
    output Running, pixel_ce, pixel_clk, hs, vs, blank, sync,
    output DrawX, DrawY, frame_start, line_start, vblank_start, FrameCount
  );

  modport slave (
    output Enable,
    input  Running, pixel_ce, pixel_clk, hs, vs, blank, sync,
    input  DrawX, DrawY, frame_start, line_start, vblank_start, FrameCount
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with frame-aligned start/stop and event strobes.
// Optional completed-frame counter enabled by defining VGA_FRAME_COUNT_EN.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter int SYNC_POL = 0,
  parameter int COORD_W  = 10
) (
  input  logic          Clk,
  input  logic          Reset_n,
  vga_timing_gen_if.master vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_VIS  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_BEG = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_BEG = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]   DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic               SYNC_ON  = (SYNC_POL != 0);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  if (CLK_DIV < 1) begin : g_chk_div
    $error("CLK_DIV must be at least 1");
  end
  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_chk_porch
    $error("porch and sync widths must be at least 1");
  end
  if ((H_TOTAL - 1) >= (1 << COORD_W) || (V_TOTAL - 1) >= (1 << COORD_W)) begin : g_chk_coord
    $error("COORD_W too narrow for H_TOTAL-1 / V_TOTAL-1");
  end

  logic [DIV_W-1:0]   div;
  logic               pixel_ce;
  logic [1:0]         state_p1;
  logic [COORD_W-1:0] hc_p1, vc_p1;
  logic               hs_p1, vs_p1, blank_p1;
  logic               frame_start_p1, line_start_p1, vblank_start_p1;
  logic [1:0]         state_p0;
  logic [COORD_W-1:0] hc_p0, vc_p0;
  logic               wrap_p0;
  logic               run_p0;

  // Pixel divider: free-running in every state, restarts at 0 on reset release.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)              div <= '0;
    else if (div == DIV_LAST)  div <= '0;
    else                       div <= div + DIV_W'(1);
  end

  assign pixel_ce = (div == DIV_LAST);

  // Stage p0: next-state counters and FSM decision for the coming pixel_ce edge.
  always_comb begin
    state_p0 = state_p1;
    hc_p0    = hc_p1;
    vc_p0    = vc_p1;
    wrap_p0  = 1'b0;
    case (state_p1)
      ST_IDLE: begin
        hc_p0 = '0;
        vc_p0 = '0;
        if (vga.Enable) state_p0 = ST_RUN;
      end
      default: begin
        if (hc_p1 == H_LAST) begin
          hc_p0 = '0;
          if (vc_p1 == V_LAST) begin
            vc_p0   = '0;
            wrap_p0 = 1'b1;
          end else begin
            vc_p0 = vc_p1 + COORD_W'(1);
          end
        end else begin
          hc_p0 = hc_p1 + COORD_W'(1);
        end
        if (wrap_p0)                            state_p0 = vga.Enable ? ST_RUN : ST_IDLE;
        else if (state_p1 == ST_RUN && !vga.Enable) state_p0 = ST_DRAIN;
      end
    endcase
    run_p0 = (state_p0 != ST_IDLE);
  end

  // Stage p1: every output decoded from the p0 values so they change together.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_p1        <= ST_IDLE;
      hc_p1           <= '0;
      vc_p1           <= '0;
      hs_p1           <= ~SYNC_ON;
      vs_p1           <= ~SYNC_ON;
      blank_p1        <= 1'b0;
      frame_start_p1  <= 1'b0;
      line_start_p1   <= 1'b0;
      vblank_start_p1 <= 1'b0;
    end else if (pixel_ce) begin
      state_p1        <= state_p0;
      hc_p1           <= hc_p0;
      vc_p1           <= vc_p0;
      hs_p1           <= (run_p0 && hc_p0 >= HS_BEG && hc_p0 < HS_END) ? SYNC_ON : ~SYNC_ON;
      vs_p1           <= (run_p0 && vc_p0 >= VS_BEG && vc_p0 < VS_END) ? SYNC_ON : ~SYNC_ON;
      blank_p1        <= run_p0 && (hc_p0 < H_VIS) && (vc_p0 < V_VIS);
      frame_start_p1  <= run_p0 && (hc_p0 == '0) && (vc_p0 == '0);
      line_start_p1   <= run_p0 && (hc_p0 == '0);
      vblank_start_p1 <= run_p0 && (hc_p0 == '0) && (vc_p0 == V_VIS);
    end else begin
      frame_start_p1  <= 1'b0;
      line_start_p1   <= 1'b0;
      vblank_start_p1 <= 1'b0;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_cnt;

  // Counts completed frames only; entry from IDLE is not a completion.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                 frame_cnt <= '0;
    else if (pixel_ce && wrap_p0) frame_cnt <= frame_cnt + 16'd1;
  end

  assign vga.FrameCount = frame_cnt;
`else
  assign vga.FrameCount = '0;
`endif

  assign vga.Running      = (state_p1 != ST_IDLE);
  assign vga.pixel_ce     = pixel_ce;
  assign vga.pixel_clk    = (div >= DIV_HALF);
  assign vga.hs           = hs_p1;
  assign vga.vs           = vs_p1;
  assign vga.blank        = blank_p1;
  assign vga.sync         = 1'b0;
  assign vga.DrawX        = hc_p1;
  assign vga.DrawY        = vc_p1;
  assign vga.frame_start  = frame_start_p1;
  assign vga.line_start   = line_start_p1;
  assign vga.vblank_start = vblank_start_p1;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 line timing, a small CLK_DIV=2 mode
// for whole-frame behaviour, and a tiny CLK_DIV=1 active-high-sync mode.
module tb_vga_timing_gen;
  logic clk    = 1'b0;
  logic rst0_n = 1'b0;
  logic rst1_n = 1'b0;
  logic rst2_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

`ifdef VGA_FRAME_COUNT_EN
  localparam int FC_EN = 1;
`else
  localparam int FC_EN = 0;
`endif

  always #5 clk = ~clk;

  vga_timing_gen_if #(.COORD_W(10)) if0 ();
  vga_timing_gen_if #(.COORD_W(10)) if1 ();
  vga_timing_gen_if #(.COORD_W(10)) if2 ();

  vga_timing_gen dut0 (.Clk(clk), .Reset_n(rst0_n), .vga(if0));

  // Small mode: H_TOTAL=24, V_TOTAL=15, 720 Clk per frame.
  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3),
    .CLK_DIV(2), .SYNC_POL(0), .COORD_W(10)
  ) dut1 (.Clk(clk), .Reset_n(rst1_n), .vga(if1));

  // Tiny mode: H_TOTAL=11, V_TOTAL=7, 77 Clk per frame.
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(1), .SYNC_POL(1), .COORD_W(10)
  ) dut2 (.Clk(clk), .Reset_n(rst2_n), .vga(if2));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (if0.DrawX !== 10'd0) begin n_fail++; $display("FAIL reset_drawx: got %0d expected 0", if0.DrawX); end
    n_checks++; if (if0.DrawY !== 10'd0) begin n_fail++; $display("FAIL reset_drawy: got %0d expected 0", if0.DrawY); end
    n_checks++; if (if0.hs !== 1'b1) begin n_fail++; $display("FAIL reset_hs: got %b expected 1", if0.hs); end
    n_checks++; if (if0.vs !== 1'b1) begin n_fail++; $display("FAIL reset_vs: got %b expected 1", if0.vs); end
    n_checks++; if (if0.blank !== 1'b0) begin n_fail++; $display("FAIL reset_blank: got %b expected 0", if0.blank); end
    n_checks++; if (if0.sync !== 1'b0) begin n_fail++; $display("FAIL reset_sync: got %b expected 0", if0.sync); end
    n_checks++; if (if0.pixel_ce !== 1'b0) begin n_fail++; $display("FAIL reset_pixel_ce: got %b expected 0", if0.pixel_ce); end
    n_checks++; if (if0.pixel_clk !== 1'b0) begin n_fail++; $display("FAIL reset_pixel_clk: got %b expected 0", if0.pixel_clk); end
    n_checks++; if (if0.frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start: got %b expected 0", if0.frame_start); end
    n_checks++; if (if0.Running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b expected 0", if0.Running); end
    n_checks++; if (if0.FrameCount !== 16'd0) begin n_fail++; $display("FAIL reset_framecount: got %0d expected 0", if0.FrameCount); end
    n_checks++; if (if2.hs !== 1'b0) begin n_fail++; $display("FAIL reset_hs_pol1: got %b expected 0", if2.hs); end
    n_checks++; if (if2.vs !== 1'b0) begin n_fail++; $display("FAIL reset_vs_pol1: got %b expected 0", if2.vs); end
  endtask

  task automatic test_default_line();
    int k, ls_cnt, fs_cnt, hs_low, hs_first, hs_last, blank_hi, blank_off, vs_low, pclk_same;
    logic prev_pclk;
    k = 0; ls_cnt = 0; fs_cnt = 0; hs_low = 0; hs_first = -1; hs_last = -1;
    blank_hi = 0; blank_off = -1; vs_low = 0; pclk_same = 0;
    if0.Enable = 1'b1;
    rst0_n     = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (if0.frame_start === 1'b1) begin k = i; break; end
    end
    n_checks++; if (k !== 2) begin n_fail++; $display("FAIL dflt_first_frame_start: got %0d Clk expected 2", k); end
    n_checks++; if (if0.DrawX !== 10'd0 || if0.DrawY !== 10'd0) begin n_fail++; $display("FAIL dflt_origin: got (%0d,%0d) expected (0,0)", if0.DrawX, if0.DrawY); end
    n_checks++; if (if0.line_start !== 1'b1) begin n_fail++; $display("FAIL dflt_line_start_at_origin: got %b expected 1", if0.line_start); end
    n_checks++; if (if0.Running !== 1'b1 || if0.blank !== 1'b1) begin n_fail++; $display("FAIL dflt_running_blank: got %b/%b expected 1/1", if0.Running, if0.blank); end
    prev_pclk = if0.pixel_clk;
    for (int i = 0; i < 1600; i++) begin
      if (if0.line_start === 1'b1) ls_cnt++;
      if (if0.frame_start === 1'b1) fs_cnt++;
      if (if0.hs === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(if0.DrawX);
        hs_last = int'(if0.DrawX);
      end
      if (if0.blank === 1'b1) blank_hi++;
      else if (blank_off < 0) blank_off = int'(if0.DrawX);
      if (if0.vs !== 1'b1) vs_low++;
      if (i > 0 && if0.pixel_clk === prev_pclk) pclk_same++;
      prev_pclk = if0.pixel_clk;
      @(negedge clk);
    end
    n_checks++; if (ls_cnt !== 1) begin n_fail++; $display("FAIL dflt_line_start_count: got %0d expected 1", ls_cnt); end
    n_checks++; if (fs_cnt !== 1) begin n_fail++; $display("FAIL dflt_frame_start_width: got %0d expected 1", fs_cnt); end
    n_checks++; if (hs_low !== 192) begin n_fail++; $display("FAIL dflt_hs_width: got %0d Clk expected 192", hs_low); end
    n_checks++; if (hs_first !== 656 || hs_last !== 751) begin n_fail++; $display("FAIL dflt_hs_window: got %0d..%0d expected 656..751", hs_first, hs_last); end
    n_checks++; if (blank_hi !== 1280 || blank_off !== 640) begin n_fail++; $display("FAIL dflt_blank: got %0d Clk, off at %0d expected 1280, 640", blank_hi, blank_off); end
    n_checks++; if (vs_low !== 0) begin n_fail++; $display("FAIL dflt_vs_line0: got %0d low Clk expected 0", vs_low); end
    n_checks++; if (pclk_same !== 0) begin n_fail++; $display("FAIL dflt_pixel_clk_period: got %0d non-toggles expected 0", pclk_same); end
    n_checks++; if (if0.line_start !== 1'b1 || if0.DrawX !== 10'd0 || if0.DrawY !== 10'd1) begin n_fail++; $display("FAIL dflt_line_period: got ls=%b (%0d,%0d) expected ls=1 (0,1)", if0.line_start, if0.DrawX, if0.DrawY); end
  endtask

  task automatic test_frame();
    int k, ls_cnt, fs_cnt, vb_cnt, vb_x, vb_y, vs_low, vs_first, vs_last, blank_hi;
    k = 0; ls_cnt = 0; fs_cnt = 0; vb_cnt = 0; vb_x = -1; vb_y = -1;
    vs_low = 0; vs_first = -1; vs_last = -1; blank_hi = 0;
    if1.Enable = 1'b1;
    rst1_n     = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (if1.frame_start === 1'b1) begin k = i; break; end
    end
    n_checks++; if (k !== 2) begin n_fail++; $display("FAIL frm_first_frame_start: got %0d Clk expected 2", k); end
    for (int i = 0; i < 720; i++) begin
      if (if1.line_start === 1'b1) ls_cnt++;
      if (if1.frame_start === 1'b1) fs_cnt++;
      if (if1.vblank_start === 1'b1) begin vb_cnt++; vb_x = int'(if1.DrawX); vb_y = int'(if1.DrawY); end
      if (if1.vs === 1'b0) begin
        vs_low++;
        if (vs_first < 0) vs_first = int'(if1.DrawY);
        vs_last = int'(if1.DrawY);
      end
      if (if1.blank === 1'b1) blank_hi++;
      @(negedge clk);
    end
    n_checks++; if (ls_cnt !== 15) begin n_fail++; $display("FAIL frm_line_starts: got %0d expected 15", ls_cnt); end
    n_checks++; if (fs_cnt !== 1) begin n_fail++; $display("FAIL frm_frame_starts: got %0d expected 1", fs_cnt); end
    n_checks++; if (vb_cnt !== 1 || vb_x !== 0 || vb_y !== 8) begin n_fail++; $display("FAIL frm_vblank: got %0d at (%0d,%0d) expected 1 at (0,8)", vb_cnt, vb_x, vb_y); end
    n_checks++; if (vs_low !== 96 || vs_first !== 10 || vs_last !== 11) begin n_fail++; $display("FAIL frm_vs: got %0d Clk rows %0d..%0d expected 96 rows 10..11", vs_low, vs_first, vs_last); end
    n_checks++; if (blank_hi !== 256) begin n_fail++; $display("FAIL frm_blank: got %0d Clk expected 256", blank_hi); end
    n_checks++; if (if1.frame_start !== 1'b1 || if1.DrawX !== 10'd0 || if1.DrawY !== 10'd0) begin n_fail++; $display("FAIL frm_period: got fs=%b (%0d,%0d) expected fs=1 (0,0)", if1.frame_start, if1.DrawX, if1.DrawY); end
  endtask

  task automatic test_enable_drop();
    int found, n, last_x, last_y, fs_cnt, strobes, run_hi;
    found = 0; n = 0; last_x = -1; last_y = -1; fs_cnt = 0; strobes = 0; run_hi = 0;
    for (int i = 0; i < 800; i++) begin
      if (if1.DrawY === 10'd3) begin found = 1; break; end
      @(negedge clk);
    end
    n_checks++; if (found !== 1) begin n_fail++; $display("FAIL drop_reach_row: got %0d expected 1", found); end
    if1.Enable = 1'b0;
    for (int i = 1; i <= 800; i++) begin
      @(negedge clk);
      if (if1.Running !== 1'b1) begin n = i; break; end
      last_x = int'(if1.DrawX);
      last_y = int'(if1.DrawY);
      if (if1.frame_start === 1'b1) fs_cnt++;
    end
    n_checks++; if (n === 0) begin n_fail++; $display("FAIL drop_idle_timeout: got Running=%b expected 0", if1.Running); end
    n_checks++; if (last_x !== 23 || last_y !== 14) begin n_fail++; $display("FAIL drop_last_pixel: got (%0d,%0d) expected (23,14)", last_x, last_y); end
    n_checks++; if (fs_cnt !== 0) begin n_fail++; $display("FAIL drop_frame_start: got %0d expected 0", fs_cnt); end
    n_checks++; if (if1.hs !== 1'b1 || if1.vs !== 1'b1 || if1.blank !== 1'b0) begin n_fail++; $display("FAIL drop_idle_levels: got hs=%b vs=%b blank=%b expected 1 1 0", if1.hs, if1.vs, if1.blank); end
    n_checks++; if (if1.DrawX !== 10'd0 || if1.DrawY !== 10'd0) begin n_fail++; $display("FAIL drop_idle_coords: got (%0d,%0d) expected (0,0)", if1.DrawX, if1.DrawY); end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (if1.frame_start === 1'b1 || if1.line_start === 1'b1 || if1.vblank_start === 1'b1) strobes++;
      if (if1.Running !== 1'b0) run_hi++;
    end
    n_checks++; if (strobes !== 0 || run_hi !== 0) begin n_fail++; $display("FAIL drop_idle_quiet: got %0d strobes %0d running expected 0 0", strobes, run_hi); end
  endtask

  task automatic test_enable_resume();
    int found, run_low;
    found = 0; run_low = 0;
    if1.Enable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (if1.frame_start === 1'b1) begin found = 1; break; end
    end
    n_checks++; if (found !== 1) begin n_fail++; $display("FAIL resume_restart: got %0d expected 1", found); end
    found = 0;
    for (int i = 0; i < 800; i++) begin
      if (if1.DrawY === 10'd3) begin found = 1; break; end
      @(negedge clk);
    end
    if1.Enable = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (if1.Running !== 1'b1) run_low++;
      if (if1.DrawY === 10'd6) begin found = found + 1; break; end
    end
    n_checks++; if (found !== 2) begin n_fail++; $display("FAIL resume_rows: got %0d expected 2", found); end
    if1.Enable = 1'b1;
    found = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (if1.Running !== 1'b1) run_low++;
      if (if1.frame_start === 1'b1) begin found = 1; break; end
    end
    n_checks++; if (found !== 1 || if1.DrawX !== 10'd0 || if1.DrawY !== 10'd0) begin n_fail++; $display("FAIL resume_frame_start: got %0d at (%0d,%0d) expected 1 at (0,0)", found, if1.DrawX, if1.DrawY); end
    n_checks++; if (run_low !== 0) begin n_fail++; $display("FAIL resume_running: got %0d low Clk expected 0", run_low); end
  endtask

  task automatic test_reset_mid();
    int found, k;
    found = 0; k = 0;
    for (int i = 0; i < 800; i++) begin
      if (if1.DrawX === 10'd8 && if1.DrawY === 10'd4) begin found = 1; break; end
      @(negedge clk);
    end
    n_checks++; if (found !== 1 || if1.blank !== 1'b1) begin n_fail++; $display("FAIL rst_mid_reach: got %0d blank=%b expected 1 1", found, if1.blank); end
    rst1_n = 1'b0;
    #1;
    n_checks++; if (if1.DrawX !== 10'd0 || if1.DrawY !== 10'd0) begin n_fail++; $display("FAIL rst_mid_coords: got (%0d,%0d) expected (0,0)", if1.DrawX, if1.DrawY); end
    n_checks++; if (if1.blank !== 1'b0 || if1.hs !== 1'b1 || if1.vs !== 1'b1 || if1.Running !== 1'b0) begin n_fail++; $display("FAIL rst_mid_levels: got blank=%b hs=%b vs=%b run=%b expected 0 1 1 0", if1.blank, if1.hs, if1.vs, if1.Running); end
    @(negedge clk);
    rst1_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (if1.frame_start === 1'b1) begin k = i; break; end
    end
    n_checks++; if (k !== 2) begin n_fail++; $display("FAIL rst_mid_restart: got %0d Clk expected 2", k); end
  endtask

  task automatic test_tiny();
    int k, pce_low, hs_hi, hs_bad, vs_hi, fs_cnt, found;
    logic [15:0] fc_hold;
    k = 0; pce_low = 0; hs_hi = 0; hs_bad = 0; vs_hi = 0; fs_cnt = 0; found = 0;
    if2.Enable = 1'b1;
    rst2_n     = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (if2.frame_start === 1'b1) begin k = i; break; end
    end
    n_checks++; if (k !== 1) begin n_fail++; $display("FAIL tiny_first_frame_start: got %0d Clk expected 1", k); end
    n_checks++; if (if2.FrameCount !== 16'd0) begin n_fail++; $display("FAIL tiny_fc_entry: got %0d expected 0", if2.FrameCount); end
    for (int i = 0; i < 77; i++) begin
      if (if2.pixel_ce !== 1'b1) pce_low++;
      if (if2.hs === 1'b1) begin hs_hi++; if (if2.DrawX !== 10'd9) hs_bad++; end
      if (if2.vs === 1'b1) vs_hi++;
      if (if2.frame_start === 1'b1) fs_cnt++;
      @(negedge clk);
    end
    n_checks++; if (pce_low !== 0) begin n_fail++; $display("FAIL tiny_pixel_ce: got %0d low Clk expected 0", pce_low); end
    n_checks++; if (hs_hi !== 7 || hs_bad !== 0) begin n_fail++; $display("FAIL tiny_hs: got %0d high (%0d off col 9) expected 7 (0)", hs_hi, hs_bad); end
    n_checks++; if (vs_hi !== 11) begin n_fail++; $display("FAIL tiny_vs: got %0d high Clk expected 11", vs_hi); end
    n_checks++; if (fs_cnt !== 1 || if2.frame_start !== 1'b1) begin n_fail++; $display("FAIL tiny_frame_period: got %0d then fs=%b expected 1 then 1", fs_cnt, if2.frame_start); end
    n_checks++; if (if2.FrameCount !== 16'(FC_EN)) begin n_fail++; $display("FAIL tiny_fc_1: got %0d expected %0d", if2.FrameCount, FC_EN); end
    repeat (154) @(negedge clk);
    n_checks++; if (if2.frame_start !== 1'b1 || if2.FrameCount !== 16'(3 * FC_EN)) begin n_fail++; $display("FAIL tiny_fc_3: got fs=%b fc=%0d expected fs=1 fc=%0d", if2.frame_start, if2.FrameCount, 3 * FC_EN); end
    if2.Enable = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (if2.Running !== 1'b1) begin found = 1; break; end
    end
    n_checks++; if (found !== 1 || if2.FrameCount !== 16'(4 * FC_EN)) begin n_fail++; $display("FAIL tiny_fc_drain: got idle=%0d fc=%0d expected 1 %0d", found, if2.FrameCount, 4 * FC_EN); end
    fc_hold = if2.FrameCount;
    repeat (30) @(negedge clk);
    n_checks++; if (if2.FrameCount !== 16'(4 * FC_EN) || if2.Running !== 1'b0) begin n_fail++; $display("FAIL tiny_fc_hold: got fc=%0d (was %0d) run=%b expected %0d 0", if2.FrameCount, fc_hold, if2.Running, 4 * FC_EN); end
  endtask

  initial begin
    if0.Enable = 1'b0;
    if1.Enable = 1'b0;
    if2.Enable = 1'b0;
    test_reset();
    test_default_line();
    test_frame();
    test_enable_drop();
    test_enable_resume();
    test_reset_mid();
    test_tiny();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
